pad_cfg_slave: RTL and testbench

Serial configuration responder inside the core that owns every pad control line driven toward the IO ring. An external host shifts 16-bit frames in over three plain input pads (SCK, SDI, CSN). The block updates per-pad registers that drive the bidir OE/CS/SL/IE/PU/PD and input PU/PD controls, and returns register contents on a bidir pad for readback. It sits between the input-pad receive path and the pad control buses of `chip_core`.

---
 rtl/pad_cfg_slave_if.sv | 30 +++
 rtl/pad_cfg_slave.sv | 196 +++++++++++++++++++
 tb/tb_pad_cfg_slave.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pad_cfg_slave_if.sv
// rtl/pad_cfg_slave_if.sv - serial configuration pad bundle between host and pad_cfg_slave
//
// Purpose: groups the three host-driven serial pads and the readback pad.
// Signals:
//   cfg_sck_i  host serial clock (asynchronous to the core clock)
//   cfg_sdi_i  host serial data, MSB first
//   cfg_csn_i  host frame select, active low
//   cfg_sdo_o  readback data toward the host
// Modports: master = host side, slave = pad_cfg_slave side.

interface pad_cfg_slave_if;
  logic cfg_sck_i;
  logic cfg_sdi_i;
  logic cfg_csn_i;
  logic cfg_sdo_o;

  modport master (
    output cfg_sck_i,
    output cfg_sdi_i,
    output cfg_csn_i,
    input  cfg_sdo_o
  );

  modport slave (
    input  cfg_sck_i,
    input  cfg_sdi_i,
    input  cfg_csn_i,
    output cfg_sdo_o
  );
endinterface

// File: rtl/pad_cfg_slave.sv
// rtl/pad_cfg_slave.sv - serial configuration responder owning all pad control registers
//
// Purpose: receives 16-bit frames {rw, addr[6:0], 2'bx, cfg[5:0]} over a
// three-wire serial port, updates per-pad control registers on frame close
// and returns register contents on cfg_sdo_o for read frames.
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   cfg               serial port (slave modport of pad_cfg_slave_if)
//   bidir_oe/cs/sl/ie/pu/pd  per-bidir-pad controls, NUM_BIDIR bits each
//   input_pu/pd       per-input-pad pulls, NUM_INPUT bits each
//   cfg_busy          synchronised frame select is active
//   frame_err         one-cycle pulse when a frame closes with a bad bit count

module pad_cfg_slave #(
  parameter int NUM_INPUT = 12,
  parameter int NUM_BIDIR = 42
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pad_cfg_slave_if.slave       cfg,
  output logic [NUM_BIDIR-1:0] bidir_oe,
  output logic [NUM_BIDIR-1:0] bidir_cs,
  output logic [NUM_BIDIR-1:0] bidir_sl,
  output logic [NUM_BIDIR-1:0] bidir_ie,
  output logic [NUM_BIDIR-1:0] bidir_pu,
  output logic [NUM_BIDIR-1:0] bidir_pd,
  output logic [NUM_INPUT-1:0] input_pu,
  output logic [NUM_INPUT-1:0] input_pd,
  output logic                 cfg_busy,
  output logic                 frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_OVER
  } state_t;

  state_t      state_q;
  state_t      state_nxt;

  // [0] first sync stage, [1] synchronised value, [2] delayed copy for edges
  logic [2:0]  sck_s;
  logic [1:0]  sdi_s;
  logic [2:0]  csn_s;

  logic        sck_rise;
  logic        sck_fall;
  logic        csn_rise;
  logic        csn_fall;

  logic [4:0]  bit_cnt;
  logic [15:0] shift_q;
  logic [15:0] shift_nxt;
  logic [7:0]  sdo_q;
  logic        rd_q;
  logic        skip_q;
  logic        sdo_out;
  logic [7:0]  rd_val;

  assign sck_rise  =  sck_s[1] & ~sck_s[2];
  assign sck_fall  = ~sck_s[1] &  sck_s[2];
  assign csn_rise  =  csn_s[1] & ~csn_s[2];
  assign csn_fall  = ~csn_s[1] &  csn_s[2];
  assign shift_nxt = {shift_q[14:0], sdi_s[1]};

  assign cfg.cfg_sdo_o = sdo_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s    <= 3'b000;
      sdi_s    <= 2'b00;
      csn_s    <= 3'b111;
      cfg_busy <= 1'b0;
    end else begin
      sck_s    <= {sck_s[1:0], cfg.cfg_sck_i};
      sdi_s    <= {sdi_s[0], cfg.cfg_sdi_i};
      csn_s    <= {csn_s[1:0], cfg.cfg_csn_i};
      // Loaded alongside csn_s[1], so it tracks the synchronised select exactly.
      cfg_busy <= ~csn_s[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (csn_rise) begin
      // Frame close outranks any SCK edge seen in the same cycle.
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (csn_fall)                    state_nxt = ST_CMD;
        ST_CMD:  if (sck_rise && bit_cnt == 5'd7)  state_nxt = ST_DATA;
        ST_DATA: if (sck_rise && bit_cnt == 5'd15) state_nxt = ST_OVER;
        ST_OVER: state_nxt = ST_OVER;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Readback value for the address byte that completes on this SCK rise.
  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_BIDIR; i++) begin
      if (shift_nxt[6:0] == 7'(i)) begin
        rd_val = {2'b00, bidir_pd[i], bidir_pu[i], bidir_ie[i],
                  bidir_sl[i], bidir_cs[i], bidir_oe[i]};
      end
    end
    for (int i = 0; i < NUM_INPUT; i++) begin
      if (shift_nxt[6:0] == 7'(64 + i)) begin
        rd_val = {2'b00, input_pd[i], input_pu[i], 4'b0000};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 5'd0;
      shift_q   <= 16'h0000;
      sdo_q     <= 8'h00;
      rd_q      <= 1'b0;
      skip_q    <= 1'b0;
      sdo_out   <= 1'b0;
      frame_err <= 1'b0;
      bidir_oe  <= '0;
      bidir_cs  <= '0;
      bidir_sl  <= '0;
      bidir_ie  <= '1;
      bidir_pu  <= '0;
      bidir_pd  <= '0;
      input_pu  <= '0;
      input_pd  <= '0;
    end else begin
      frame_err <= 1'b0;
      sdo_out   <= (state_q == ST_DATA && rd_q && !csn_rise) ? sdo_q[7] : 1'b0;

      if (csn_rise) begin
        if (bit_cnt == 5'd16) begin
          if (shift_q[15]) begin
            for (int i = 0; i < NUM_BIDIR; i++) begin
              if (shift_q[14:8] == 7'(i)) begin
                bidir_oe[i] <= shift_q[0];
                bidir_cs[i] <= shift_q[1];
                bidir_sl[i] <= shift_q[2];
                bidir_ie[i] <= shift_q[3];
                bidir_pu[i] <= shift_q[4];
                bidir_pd[i] <= shift_q[5];
              end
            end
            for (int i = 0; i < NUM_INPUT; i++) begin
              if (shift_q[14:8] == 7'(64 + i)) begin
                input_pu[i] <= shift_q[4];
                input_pd[i] <= shift_q[5];
              end
            end
          end
        end else if (bit_cnt != 5'd0) begin
          frame_err <= 1'b1;
        end
        bit_cnt <= 5'd0;
        rd_q    <= 1'b0;
        skip_q  <= 1'b0;
      end else begin
        if (state_q == ST_IDLE && csn_fall) begin
          bit_cnt <= 5'd0;
          shift_q <= 16'h0000;
        end

        if (sck_rise && state_q != ST_IDLE) begin
          // Saturate at 17 so any overlong frame still reads as malformed.
          if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
          if (state_q == ST_CMD || state_q == ST_DATA) shift_q <= shift_nxt;
          if (state_q == ST_CMD && bit_cnt == 5'd7) begin
            rd_q   <= ~shift_nxt[7];
            sdo_q  <= shift_nxt[7] ? 8'h00 : rd_val;
            skip_q <= 1'b1;
          end
        end

        // The fall that closes bit 8 must not shift, otherwise the host
        // would miss the MSB on the 9th rise.
        if (sck_fall && state_q == ST_DATA) begin
          if (skip_q) skip_q <= 1'b0;
          else        sdo_q  <= {sdo_q[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_pad_cfg_slave.sv
// tb/tb_pad_cfg_slave.sv - directed self-checking bench for pad_cfg_slave

module tb_pad_cfg_slave;

  localparam int NI = 12;
  localparam int NB = 42;
  localparam logic [NB-1:0] ONES = {NB{1'b1}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NB-1:0] bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic [NI-1:0] input_pu, input_pd;
  logic cfg_busy, frame_err;

  pad_cfg_slave_if bus ();

  pad_cfg_slave #(.NUM_INPUT(NI), .NUM_BIDIR(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg      (bus),
    .bidir_oe (bidir_oe),
    .bidir_cs (bidir_cs),
    .bidir_sl (bidir_sl),
    .bidir_ie (bidir_ie),
    .bidir_pu (bidir_pu),
    .bidir_pd (bidir_pd),
    .input_pu (input_pu),
    .input_pd (input_pd),
    .cfg_busy (cfg_busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int err_cnt = 0;
  int e0;
  logic [31:0] rx;

  always @(posedge clk) if (frame_err) err_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start_frame();
    bus.cfg_csn_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    bus.cfg_csn_i = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Shifts nbits MSB first; rx captures cfg_sdo_o just before each rise.
  task automatic shift_bits(input logic [31:0] data, input int nbits, input bit last_with_csn);
    rx = 32'h0;
    for (int i = 0; i < nbits; i++) begin
      bus.cfg_sck_i = 1'b0;
      bus.cfg_sdi_i = data[nbits-1-i];
      repeat (4) @(negedge clk);
      rx = {rx[30:0], bus.cfg_sdo_o};
      bus.cfg_sck_i = 1'b1;
      if (last_with_csn && i == nbits - 1) bus.cfg_csn_i = 1'b1;
      repeat (4) @(negedge clk);
    end
    bus.cfg_sck_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] data, input int nbits);
    start_frame();
    shift_bits(data, nbits, 1'b0);
    end_frame();
  endtask

  task automatic check_bidir(input string tag, input logic [NB-1:0] exp_oe, input logic [NB-1:0] exp_ie);
    check({tag, "_oe"}, 64'(bidir_oe), 64'(exp_oe));
    check({tag, "_ie"}, 64'(bidir_ie), 64'(exp_ie));
    check({tag, "_other"}, 64'(bidir_cs | bidir_sl | bidir_pu | bidir_pd), 64'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cfg_sck_i = 1'b0;
    bus.cfg_sdi_i = 1'b0;
    bus.cfg_csn_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check_bidir("rst", '0, ONES);
    check("rst_in_pu", 64'(input_pu), 64'h0);
    check("rst_in_pd", 64'(input_pd), 64'h0);
    check("rst_sdo", 64'(bus.cfg_sdo_o), 64'h0);
    check("rst_busy", 64'(cfg_busy), 64'h0);
    check("rst_err", 64'(frame_err), 64'h0);

    // Bidir write 0x8509 with busy and commit latency
    bus.cfg_csn_i = 1'b0;
    @(negedge clk);
    check("busy_lat1", 64'(cfg_busy), 64'h0);
    @(negedge clk);
    check("busy_lat2", 64'(cfg_busy), 64'h1);
    repeat (2) @(negedge clk);
    shift_bits(32'h8509, 16, 1'b0);
    check("wr_sdo_zero", 64'(rx[15:0]), 64'h0);
    e0 = err_cnt;
    bus.cfg_csn_i = 1'b1;
    repeat (2) @(negedge clk);
    check("wr_lat_before", 64'(bidir_oe), 64'h0);
    @(negedge clk);
    check_bidir("wr5", 42'h20, ONES);
    repeat (4) @(negedge clk);
    check("wr5_err", 64'(err_cnt - e0), 64'h0);
    check("wr5_busy_off", 64'(cfg_busy), 64'h0);

    // Readback of pad 5
    e0 = err_cnt;
    frame(32'h0500, 16);
    check("rd5_cmd_phase", 64'(rx[15:8]), 64'h00);
    check("rd5_data", 64'(rx[7:0]), 64'h09);
    check("rd5_sdo_after", 64'(bus.cfg_sdo_o), 64'h0);
    check("rd5_err", 64'(err_cnt - e0), 64'h0);
    check_bidir("rd5", 42'h20, ONES);

    // Input pad 3 write and readback
    frame(32'hC33F, 16);
    check("in3_pu", 64'(input_pu), 64'h008);
    check("in3_pd", 64'(input_pd), 64'h008);
    check_bidir("in3", 42'h20, ONES);
    frame(32'h4300, 16);
    check("in3_rd", 64'(rx[7:0]), 64'h30);

    // Malformed frames
    e0 = err_cnt;
    frame(32'h451F, 15);
    check("len15_err", 64'(err_cnt - e0), 64'h1);
    check_bidir("len15", 42'h20, ONES);
    e0 = err_cnt;
    frame(32'h1147F, 17);
    check("len17_err", 64'(err_cnt - e0), 64'h1);
    check_bidir("len17", 42'h20, ONES);
    e0 = err_cnt;
    frame(32'h0, 0);
    check("len0_err", 64'(err_cnt - e0), 64'h0);

    // Out-of-range writes
    e0 = err_cnt;
    frame(32'hB23F, 16);
    frame(32'hE43F, 16);
    check("oor_err", 64'(err_cnt - e0), 64'h0);
    check_bidir("oor", 42'h20, ONES);
    check("oor_in_pu", 64'(input_pu), 64'h008);

    // CSN rise coincident with the 16th SCK rise: edge not counted
    e0 = err_cnt;
    start_frame();
    shift_bits(32'h8A3F, 16, 1'b1);
    repeat (6) @(negedge clk);
    check("prec_err", 64'(err_cnt - e0), 64'h1);
    check_bidir("prec", 42'h20, ONES);

    // Asynchronous reset mid-frame
    start_frame();
    shift_bits(32'h85, 8, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_bidir("mrst", '0, ONES);
    check("mrst_in_pu", 64'(input_pu), 64'h0);
    check("mrst_sdo", 64'(bus.cfg_sdo_o), 64'h0);
    check("mrst_busy", 64'(cfg_busy), 64'h0);
    bus.cfg_csn_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e0 = err_cnt;
    repeat (4) @(negedge clk);
    check("mrst_busy_rel", 64'(cfg_busy), 64'h0);
    frame(32'h8509, 16);
    check_bidir("post_rst_wr", 42'h20, ONES);
    check("post_rst_err", 64'(err_cnt - e0), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
